// File: rtl/risc_toy_pkg.sv
// Types and defaults shared by the memory-port arbiter and its return-tag pipe.
package risc_toy_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_I    = 2'b01,
    TAG_D    = 2'b10
  } tag_t;

  localparam int LAT_DEF      = 2;
  localparam int MAX_DWIN_DEF = 4;

  // A flush only kills fetch returns; load returns pass through untouched.
  function automatic tag_t squash_fetch(input tag_t tag, input logic squash);
    return (squash && tag == TAG_I) ? TAG_NONE : tag;
  endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// LAT-deep shift register recording which side owns each outstanding read.
module arb_tag_pipe
  import risc_toy_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic clk,
  input  logic srst,
  input  tag_t tag_in,
  input  logic squash_i,
  output tag_t tail
);

  tag_t stage_reg [LAT];

  generate
    for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
      tag_t stage_next;

      // Squash applies on the way in, so the accepted-this-cycle fetch dies too.
      if (gi == 0) begin : g_head
        assign stage_next = squash_fetch(tag_in, squash_i);
      end else begin : g_body
        assign stage_next = squash_fetch(stage_reg[gi-1], squash_i);
      end

      always_ff @(posedge clk) begin
        if (srst) begin
          stage_reg[gi] <= TAG_NONE;
        end else begin
          stage_reg[gi] <= stage_next;
        end
      end
    end
  endgenerate

  assign tail = stage_reg[LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one pipelined single-port memory between fetch (I) and data (D) sides,
// D first, with a bound on how long a pending fetch can be starved.
module mem_port_arbiter
  import risc_toy_pkg::*;
#(
  parameter int LAT      = LAT_DEF,
  parameter int MAX_DWIN = MAX_DWIN_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_REQ,
  input  logic [29:0] I_ADDR,
  input  logic        I_FLUSH,
  output logic        I_STALL,
  output logic        I_VALID,
  output logic [31:0] I_RDATA,
  input  logic        D_REQ,
  input  logic        D_RW,
  input  logic [29:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic        D_STALL,
  output logic        D_VALID,
  output logic [31:0] D_RDATA,
  output logic        M_REQ,
  output logic        M_RW,
  output logic [29:0] M_ADDR,
  output logic [31:0] M_WDATA,
  input  logic        M_GNT,
  input  logic [31:0] M_RDATA
);

  localparam logic [3:0] DWIN_LIMIT = 4'(MAX_DWIN);

  logic [3:0] dwin_cnt_reg;
  logic [3:0] dwin_cnt_next;
  logic       sel_d;
  logic       sel_i;
  logic       accept_d;
  logic       accept_i;
  tag_t       new_tag;
  tag_t       tail_tag;

  // Nothing is issued while reset is held, so both requesters see a stall.
  assign sel_d = ~RST & D_REQ & ~(I_REQ & (dwin_cnt_reg == DWIN_LIMIT));
  assign sel_i = ~RST & I_REQ & ~sel_d;

  assign M_REQ   = sel_d | sel_i;
  assign M_RW    = sel_d & D_RW;
  assign M_ADDR  = sel_d ? D_ADDR : I_ADDR;
  assign M_WDATA = sel_d ? D_WDATA : 32'h0;

  assign accept_d = sel_d & M_GNT;
  assign accept_i = sel_i & M_GNT;

  assign I_STALL = I_REQ & ~accept_i;
  assign D_STALL = D_REQ & ~accept_d;

  always_comb begin
    new_tag = TAG_NONE;
    if (accept_d && !D_RW) begin
      new_tag = TAG_D;
    end else if (accept_i) begin
      new_tag = TAG_I;
    end
  end

  always_comb begin
    dwin_cnt_next = dwin_cnt_reg;
    if (!I_REQ || accept_i) begin
      dwin_cnt_next = 4'd0;
    end else if (accept_d && dwin_cnt_reg < DWIN_LIMIT) begin
      dwin_cnt_next = dwin_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dwin_cnt_reg <= 4'd0;
    end else begin
      dwin_cnt_reg <= dwin_cnt_next;
    end
  end

  arb_tag_pipe #(
    .LAT (LAT)
  ) u_tag_pipe (
    .clk      (CLK),
    .srst     (RST),
    .tag_in   (new_tag),
    .squash_i (I_FLUSH),
    .tail     (tail_tag)
  );

  assign I_VALID = ~RST & (tail_tag == TAG_I);
  assign D_VALID = ~RST & (tail_tag == TAG_D);
  assign I_RDATA = M_RDATA;
  assign D_RDATA = M_RDATA;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency memory model (LAT=2).
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        I_REQ, I_FLUSH, I_STALL, I_VALID;
  logic [29:0] I_ADDR;
  logic [31:0] I_RDATA;
  logic        D_REQ, D_RW, D_STALL, D_VALID;
  logic [29:0] D_ADDR;
  logic [31:0] D_WDATA, D_RDATA;
  logic        M_REQ, M_RW, M_GNT;
  logic [29:0] M_ADDR;
  logic [31:0] M_WDATA, M_RDATA;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem [256];
  logic [31:0] rd_pipe [2];

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.LAT(2), .MAX_DWIN(4)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_FLUSH(I_FLUSH),
    .I_STALL(I_STALL), .I_VALID(I_VALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_STALL(D_STALL), .D_VALID(D_VALID), .D_RDATA(D_RDATA),
    .M_REQ(M_REQ), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_GNT(M_GNT), .M_RDATA(M_RDATA)
  );

  // Memory model: word a initially holds 0xC0DE0000+a; read data appears 2 cycles after accept.
  always @(posedge CLK) begin
    if (RST) begin
      for (int a = 0; a < 256; a++) mem[a] <= 32'hC0DE0000 + 32'(a);
      rd_pipe[0] <= 32'h0;
      rd_pipe[1] <= 32'h0;
    end else begin
      if (M_REQ && M_GNT && M_RW) mem[M_ADDR[7:0]] <= M_WDATA;
      rd_pipe[0] <= (M_REQ && M_GNT && !M_RW) ? mem[M_ADDR[7:0]] : 32'h0;
      rd_pipe[1] <= rd_pipe[0];
    end
  end
  assign M_RDATA = rd_pipe[1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    I_REQ = 0; I_FLUSH = 0; D_REQ = 0; D_RW = 0; M_GNT = 1;
  endtask

  initial begin
    RST = 1; I_REQ = 1; D_REQ = 1; I_FLUSH = 0; D_RW = 0; M_GNT = 1;
    I_ADDR = 30'h0; D_ADDR = 30'h0; D_WDATA = 32'h0;

    // 1. reset
    #1;
    check("rst_m_req", 32'(M_REQ), 32'd0);
    check("rst_i_stall", 32'(I_STALL), 32'd1);
    check("rst_d_stall", 32'(D_STALL), 32'd1);
    check("rst_valid", {30'd0, I_VALID, D_VALID}, 32'd0);
    tick(); tick();
    RST = 0; idle();
    for (int k = 0; k < 2; k++) begin
      #1;
      check("post_rst_valid", {30'd0, I_VALID, D_VALID}, 32'd0);
      tick();
    end

    // 2. back-to-back fetches 0x10..0x12, data returns 2 cycles after each accept
    for (int k = 0; k < 5; k++) begin
      I_REQ = (k < 3);
      I_ADDR = 30'h10 + 30'(k);
      #1;
      if (k < 3) check("fetch_stall", 32'(I_STALL), 32'd0);
      check("fetch_valid", 32'(I_VALID), 32'(k >= 2));
      if (k >= 2) check("fetch_rdata", I_RDATA, 32'hC0DE0010 + 32'(k - 2));
      tick();
    end
    idle(); tick();

    // 3. contention: four D grants then one I grant, repeating
    I_REQ = 1; I_ADDR = 30'h40; D_REQ = 1; D_RW = 0; D_ADDR = 30'h30;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("cont_i_stall", 32'(I_STALL), 32'((k % 5) != 4));
      check("cont_d_stall", 32'(D_STALL), 32'((k % 5) == 4));
      check("cont_m_addr", 32'(M_ADDR), ((k % 5) == 4) ? 32'h40 : 32'h30);
      tick();
    end
    idle(); tick(); tick(); tick();

    // 4. D write, then read back
    D_REQ = 1; D_RW = 1; D_ADDR = 30'h20; D_WDATA = 32'hDEADBEEF;
    #1;
    check("wr_m_rw", 32'(M_RW), 32'd1);
    check("wr_m_wdata", M_WDATA, 32'hDEADBEEF);
    check("wr_d_stall", 32'(D_STALL), 32'd0);
    tick();
    idle(); tick();
    check("wr_no_d_valid", 32'(D_VALID), 32'd0);
    D_REQ = 1; D_RW = 0; D_ADDR = 30'h20;
    tick();
    idle(); tick();
    check("rdback_valid", 32'(D_VALID), 32'd1);
    check("rdback_data", D_RDATA, 32'hDEADBEEF);
    tick();

    // 5. flush kills the in-flight fetch but not a load accepted in the flush cycle
    I_REQ = 1; I_ADDR = 30'h50;
    tick();
    I_REQ = 0; I_FLUSH = 1; D_REQ = 1; D_RW = 0; D_ADDR = 30'h21;
    #1;
    check("flush_d_stall", 32'(D_STALL), 32'd0);
    tick();
    idle();
    #1;
    check("flush_no_i_valid", 32'(I_VALID), 32'd0);
    tick();
    check("flush_d_valid", 32'(D_VALID), 32'd1);
    check("flush_d_rdata", D_RDATA, 32'hC0DE0021);
    tick(); tick();

    // 6. memory withholds grant for three cycles
    D_REQ = 1; D_RW = 0; D_ADDR = 30'h22; M_GNT = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("nogrant_d_stall", 32'(D_STALL), 32'd1);
      check("nogrant_m_addr", 32'(M_ADDR), 32'h22);
      check("nogrant_d_valid", 32'(D_VALID), 32'd0);
      tick();
    end
    M_GNT = 1;
    #1;
    check("grant_d_stall", 32'(D_STALL), 32'd0);
    tick();
    idle(); tick();
    check("grant_d_valid", 32'(D_VALID), 32'd1);
    check("grant_d_rdata", D_RDATA, 32'hC0DE0022);
    tick();

    // 7. reset while a fetch is in flight drops its return
    I_REQ = 1; I_ADDR = 30'h60;
    tick();
    idle(); RST = 1;
    #1;
    check("midrst_i_valid0", 32'(I_VALID), 32'd0);
    tick();
    RST = 0;
    #1;
    check("midrst_i_valid1", 32'(I_VALID), 32'd0);
    tick();
    check("midrst_i_valid2", 32'(I_VALID), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
